// File: rtl/sprite_palette_bank_pkg.sv
// Shared types and constants for the sprite palette bank: colour struct,
// default 16-colour table, commit FSM state enum and channel helpers.
package palette_pkg;

    localparam int PKG_COLOR_W     = 4;
    localparam int DEFAULT_ENTRIES = 16;

    typedef struct packed {
        logic [PKG_COLOR_W-1:0] r;
        logic [PKG_COLOR_W-1:0] g;
        logic [PKG_COLOR_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SYNC    = 2'd2
    } pal_state_e;

    // Classic 16-colour table, packed {r,g,b}; entry 0 is black.
    localparam logic [3*PKG_COLOR_W-1:0] DEFAULT_PAL [DEFAULT_ENTRIES] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    // Default colour for a (truncated) colour index; wraps every 16 entries.
    function automatic rgb_t default_rgb(input int idx);
        return rgb_t'(DEFAULT_PAL[idx % DEFAULT_ENTRIES]);
    endfunction

    // Rescale a 4-bit table channel to a channel of width w (identity for w=4).
    function automatic int scale_ch(input int ch4, input int w);
        return (ch4 * ((1 << w) - 1)) / 15;
    endfunction

endpackage

// File: rtl/sprite_palette_bank_if.sv
// Lookup / write / commit bus of the sprite palette bank.
// master: address generators and CPU side; slave: the palette bank.
interface sprite_palette_bank_if #(
    parameter int IDX_W   = 4,
    parameter int NUM_PAL = 4,
    parameter int COLOR_W = 4
);
    localparam int PAL_W = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;

    logic                 frame_start;
    logic                 rd_valid;
    logic [PAL_W-1:0]     rd_pal;
    logic [IDX_W-1:0]     rd_idx;
    logic                 out_valid;
    logic [COLOR_W-1:0]   red;
    logic [COLOR_W-1:0]   green;
    logic [COLOR_W-1:0]   blue;
    logic                 transparent;
    logic                 wr_en;
    logic [PAL_W-1:0]     wr_pal;
    logic [IDX_W-1:0]     wr_idx;
    logic [3*COLOR_W-1:0] wr_rgb;
    logic                 wr_ready;
    logic                 commit_req;
    logic                 commit_busy;

    modport master (
        output frame_start, rd_valid, rd_pal, rd_idx,
               wr_en, wr_pal, wr_idx, wr_rgb, commit_req,
        input  out_valid, red, green, blue, transparent, wr_ready, commit_busy
    );

    modport slave (
        input  frame_start, rd_valid, rd_pal, rd_idx,
               wr_en, wr_pal, wr_idx, wr_rgb, commit_req,
        output out_valid, red, green, blue, transparent, wr_ready, commit_busy
    );
endinterface

// File: rtl/sprite_palette_bank_ram.sv
// One palette bank: per-entry registers with one write port and two
// combinational read ports (lookup and copy). Reset reloads every entry
// with its default colour, so the storage is register based.
module palette_bank_ram
    import palette_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int ADDR_W  = 6,
    parameter int COLOR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [3*COLOR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]    lk_addr,
    output logic [3*COLOR_W-1:0] lk_data,
    input  logic [ADDR_W-1:0]    cp_addr,
    output logic [3*COLOR_W-1:0] cp_data
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int RGB_W = 3 * COLOR_W;

    logic [RGB_W-1:0] mem_rd [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam rgb_t DEF_RGB = default_rgb(gi % (1 << IDX_W));
            localparam logic [RGB_W-1:0] DEF_WORD = {
                COLOR_W'(scale_ch(int'(DEF_RGB.r), COLOR_W)),
                COLOR_W'(scale_ch(int'(DEF_RGB.g), COLOR_W)),
                COLOR_W'(scale_ch(int'(DEF_RGB.b), COLOR_W))
            };

            logic [RGB_W-1:0] entry_q;
            logic [RGB_W-1:0] entry_d;

            // Next value of this entry: write data when addressed, else hold.
            always_comb begin
                entry_d = entry_q;
                if (we && (waddr == ADDR_W'(gi))) begin
                    entry_d = wdata;
                end
            end

            // Entry register, reloaded with its default colour on reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_q <= DEF_WORD;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign mem_rd[gi] = entry_q;
        end
    endgenerate

    assign lk_data = mem_rd[lk_addr];
    assign cp_data = mem_rd[cp_addr];

endmodule

// File: rtl/sprite_palette_bank.sv
// Double-buffered, run-time writable palette lookup for sprite/background
// pixels. Writes land in the shadow bank; a commit swaps banks at the next
// frame_start and then copies the new active bank into the new shadow bank.
// Optional feature macro: PALETTE_TRANSPARENCY_EN (index 0 is transparent).
module sprite_palette_bank
    import palette_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int NUM_PAL = 4,
    parameter int COLOR_W = 4
) (
    input  logic Clk,
    input  logic Reset,
    sprite_palette_bank_if.slave bus
);
    localparam int PAL_W   = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;
    localparam int ADDR_W  = PAL_W + IDX_W;
    localparam int ENTRIES = NUM_PAL * (1 << IDX_W);
    localparam int CNT_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int RGB_W   = 3 * COLOR_W;
    localparam logic SEL_A = 1'b0;

    pal_state_e       state_q, state_d;
    logic             act_sel_q, act_sel_d;     // SEL_A: bank A active
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             transp_q, transp_d;

    logic             wr_ready;
    logic             copy_active;
    logic             sh_we;
    logic [ADDR_W-1:0] sh_addr;
    logic [RGB_W-1:0] sh_wdata;
    logic [ADDR_W-1:0] lk_addr;
    logic [ADDR_W-1:0] cp_addr;
    logic [RGB_W-1:0] lk_a, lk_b, cp_a, cp_b;
    logic [RGB_W-1:0] act_lk, act_cp;
    logic             we_a, we_b;

    // Commit FSM: arm on commit_req, swap on frame_start, then copy one entry per cycle.
    always_comb begin
        state_d   = state_q;
        act_sel_d = act_sel_q;
        cnt_d     = cnt_q;
        wr_ready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_ready = 1'b1;
                if (bus.commit_req) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                wr_ready = !bus.frame_start;
                if (bus.frame_start) begin
                    state_d   = ST_SYNC;
                    act_sel_d = !act_sel_q;
                    cnt_d     = '0;
                end
            end
            ST_SYNC: begin
                if (cnt_q == CNT_W'(ENTRIES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, active-bank select and copy counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            act_sel_q <= SEL_A;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            act_sel_q <= act_sel_d;
            cnt_q     <= cnt_d;
        end
    end

    // The shadow bank takes either CPU writes or, during SYNC, the copy stream.
    assign copy_active = (state_q == ST_SYNC);
    assign cp_addr     = ADDR_W'(cnt_q);
    assign lk_addr     = {bus.rd_pal, bus.rd_idx};
    assign act_lk      = (act_sel_q == SEL_A) ? lk_a : lk_b;
    assign act_cp      = (act_sel_q == SEL_A) ? cp_a : cp_b;
    assign sh_we       = (bus.wr_en && wr_ready) || copy_active;
    assign sh_addr     = copy_active ? cp_addr : {bus.wr_pal, bus.wr_idx};
    assign sh_wdata    = copy_active ? act_cp : bus.wr_rgb;
    assign we_a        = sh_we && (act_sel_q != SEL_A);
    assign we_b        = sh_we && (act_sel_q == SEL_A);

    palette_bank_ram #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) u_bank_a (
        .clk     (Clk),
        .rst     (Reset),
        .we      (we_a),
        .waddr   (sh_addr),
        .wdata   (sh_wdata),
        .lk_addr (lk_addr),
        .lk_data (lk_a),
        .cp_addr (cp_addr),
        .cp_data (cp_a)
    );

    palette_bank_ram #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) u_bank_b (
        .clk     (Clk),
        .rst     (Reset),
        .we      (we_b),
        .waddr   (sh_addr),
        .wdata   (sh_wdata),
        .lk_addr (lk_addr),
        .lk_data (lk_b),
        .cp_addr (cp_addr),
        .cp_data (cp_b)
    );

    // Lookup result: capture on a request, hold the colour otherwise.
    always_comb begin
        out_valid_d = bus.rd_valid;
        rgb_d       = rgb_q;
        transp_d    = transp_q;
        if (bus.rd_valid) begin
`ifdef PALETTE_TRANSPARENCY_EN
            if (bus.rd_idx == '0) begin
                rgb_d    = '0;
                transp_d = 1'b1;
            end else begin
                rgb_d    = act_lk;
                transp_d = 1'b0;
            end
`else
            rgb_d    = act_lk;
            transp_d = 1'b0;
`endif
        end
    end

    // Registered lookup outputs (1-cycle latency).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            rgb_q       <= '0;
            transp_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            rgb_q       <= rgb_d;
            transp_q    <= transp_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.red         = rgb_q[RGB_W-1 -: COLOR_W];
    assign bus.green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue        = rgb_q[COLOR_W-1:0];
    assign bus.transparent = transp_q;
    assign bus.wr_ready    = wr_ready;
    assign bus.commit_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Randomised bench for sprite_palette_bank against a palette-level model:
// an active and a shadow colour table, a pending-commit flag and a count of
// remaining busy cycles after a swap.
module tb_sprite_palette_bank;
    localparam int IDX_W   = 4;
    localparam int NUM_PAL = 4;
    localparam int COLOR_W = 4;
    localparam int ENTRIES = NUM_PAL * (1 << IDX_W);

    localparam logic [11:0] REF_DEFAULT [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    sprite_palette_bank_if #(.IDX_W(IDX_W), .NUM_PAL(NUM_PAL), .COLOR_W(COLOR_W)) bus ();

    sprite_palette_bank #(.IDX_W(IDX_W), .NUM_PAL(NUM_PAL), .COLOR_W(COLOR_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Reference model state
    logic [11:0] act_m [ENTRIES];
    logic [11:0] sh_m  [ENTRIES];
    bit          pending_m;
    int          sync_left_m;
    bit          exp_valid;
    logic [11:0] exp_rgb;
    bit          exp_transp;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            act_m[i] = REF_DEFAULT[i % 16];
            sh_m[i]  = REF_DEFAULT[i % 16];
        end
        pending_m   = 1'b0;
        sync_left_m = 0;
        exp_valid   = 1'b0;
        exp_rgb     = 12'h000;
        exp_transp  = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.frame_start = 1'b0;
        bus.rd_valid    = 1'b0;
        bus.rd_pal      = '0;
        bus.rd_idx      = '0;
        bus.wr_en       = 1'b0;
        bus.wr_pal      = '0;
        bus.wr_idx      = '0;
        bus.wr_rgb      = '0;
        bus.commit_req  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".out_valid"},   32'(bus.out_valid), 32'(exp_valid));
        check_eq({tag, ".rgb"},         32'({bus.red, bus.green, bus.blue}), 32'(exp_rgb));
        check_eq({tag, ".transparent"}, 32'(bus.transparent), 32'(exp_transp));
    endtask

    // One clock: inputs are already driven; check handshake outputs, advance
    // the model over the coming edge, then check registered outputs.
    task automatic step(input string tag);
        bit exp_ready;
        int a;
        #2;
        exp_ready = (sync_left_m == 0) && !(pending_m && bus.frame_start);
        check_eq({tag, ".wr_ready"},    32'(bus.wr_ready), 32'(exp_ready));
        check_eq({tag, ".commit_busy"}, 32'(bus.commit_busy), 32'(pending_m || (sync_left_m > 0)));
        exp_valid = bus.rd_valid;
        if (bus.rd_valid) begin
            a          = int'(bus.rd_pal) * (1 << IDX_W) + int'(bus.rd_idx);
            exp_rgb    = act_m[a];
            exp_transp = 1'b0;
`ifdef PALETTE_TRANSPARENCY_EN
            if (bus.rd_idx == 0) begin
                exp_rgb    = 12'h000;
                exp_transp = 1'b1;
            end
`endif
        end
        if (bus.wr_en && exp_ready) begin
            sh_m[int'(bus.wr_pal) * (1 << IDX_W) + int'(bus.wr_idx)] = bus.wr_rgb;
        end
        if (sync_left_m > 0) begin
            sync_left_m--;
        end else if (pending_m) begin
            if (bus.frame_start) begin
                act_m       = sh_m;
                pending_m   = 1'b0;
                sync_left_m = ENTRIES;
            end
        end else if (bus.commit_req) begin
            pending_m = 1'b1;
        end
        @(posedge Clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic lookup(input int pal, input int idx, input string tag);
        clear_inputs();
        bus.rd_valid = 1'b1;
        bus.rd_pal   = 2'(pal);
        bus.rd_idx   = 4'(idx);
        step(tag);
    endtask

    task automatic commit_and_swap(input string tag);
        clear_inputs();
        bus.commit_req = 1'b1;
        step({tag, ".req"});
        clear_inputs();
        step({tag, ".pend"});
        clear_inputs();
        bus.frame_start = 1'b1;
        bus.rd_valid    = 1'b1;
        bus.rd_pal      = 2'd1;
        bus.rd_idx      = 4'd3;
        step({tag, ".swap"});
    endtask

    initial begin
        clear_inputs();
        model_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check_outputs("reset");
        check_eq("reset.wr_ready",    32'(bus.wr_ready), 32'd1);
        check_eq("reset.commit_busy", 32'(bus.commit_busy), 32'd0);
        Reset = 1'b0;

        // Directed: default lookup, shadow write invisible before commit.
        lookup(0, 1, "lk_default");
        check_eq("lk_default.value", 32'({bus.red, bus.green, bus.blue}), 32'h00A);
        clear_inputs();
        bus.wr_en  = 1'b1;
        bus.wr_pal = 2'd1;
        bus.wr_idx = 4'd3;
        bus.wr_rgb = 12'hF00;
        step("wr_f00");
        lookup(1, 3, "lk_before_commit");
        check_eq("lk_before_commit.value", 32'({bus.red, bus.green, bus.blue}), 32'h0AA);

        // Swap: lookup on the swap edge still sees the old bank.
        commit_and_swap("commit1");
        check_eq("swap_edge.value", 32'({bus.red, bus.green, bus.blue}), 32'h0AA);
        lookup(1, 3, "lk_after_swap");
        check_eq("lk_after_swap.value", 32'({bus.red, bus.green, bus.blue}), 32'hF00);

        // Rest of SYNC with writes attempted every cycle; none may land.
        for (int i = 0; i < ENTRIES - 1; i++) begin
            clear_inputs();
            bus.wr_en  = 1'b1;
            bus.wr_pal = 2'($urandom_range(0, 3));
            bus.wr_idx = 4'($urandom_range(0, 15));
            bus.wr_rgb = 12'($urandom);
            bus.commit_req  = 1'($urandom_range(0, 1));
            bus.frame_start = 1'($urandom_range(0, 1));
            step("sync_wr");
        end

        // Second commit with no writes keeps F00; idx 0 exercises transparency.
        commit_and_swap("commit2");
        lookup(1, 3, "lk_commit2");
        check_eq("lk_commit2.value", 32'({bus.red, bus.green, bus.blue}), 32'hF00);
        lookup(2, 0, "lk_idx0");
        for (int i = 0; i < ENTRIES; i++) begin
            clear_inputs();
            step("sync2");
        end

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            clear_inputs();
            bus.rd_valid    = ($urandom_range(0, 3) != 0);
            bus.rd_pal      = 2'($urandom_range(0, 3));
            bus.rd_idx      = 4'($urandom_range(0, 15));
            bus.wr_en       = 1'($urandom_range(0, 1));
            bus.wr_pal      = 2'($urandom_range(0, 3));
            bus.wr_idx      = 4'($urandom_range(0, 15));
            bus.wr_rgb      = 12'($urandom);
            bus.commit_req  = ($urandom_range(0, 19) == 0);
            bus.frame_start = ($urandom_range(0, 29) == 0);
            step("rand");
        end
        for (int i = 0; i < 2 * ENTRIES; i++) begin
            clear_inputs();
            step("drain");
        end

        // Reset at copy count 20 of SYNC.
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            bus.wr_en  = 1'b1;
            bus.wr_pal = 2'($urandom_range(0, 3));
            bus.wr_idx = 4'($urandom_range(0, 15));
            bus.wr_rgb = 12'($urandom);
            step("pre_rst_wr");
        end
        commit_and_swap("commit3");
        for (int i = 0; i < 20; i++) begin
            clear_inputs();
            step("sync3");
        end
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check_outputs("midsync_rst");
        check_eq("midsync_rst.commit_busy", 32'(bus.commit_busy), 32'd0);
        check_eq("midsync_rst.wr_ready",    32'(bus.wr_ready), 32'd1);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int a = 0; a < ENTRIES; a++) begin
            lookup(a / (1 << IDX_W), a % (1 << IDX_W), "post_rst_sweep");
        end
        // Bank select back to A: a shadow write must not show until a swap.
        clear_inputs();
        bus.wr_en  = 1'b1;
        bus.wr_pal = 2'd0;
        bus.wr_idx = 4'd5;
        bus.wr_rgb = 12'h123;
        step("post_rst_wr");
        lookup(0, 5, "post_rst_lk");
        check_eq("post_rst_lk.value", 32'({bus.red, bus.green, bus.blue}), 32'hA0A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_palette_bank.md
# sprite_palette_bank

Parametrised, run-time-writable colour lookup for sprite and background pixel indices. It replaces the fixed per-sprite palette ROMs with `NUM_PAL` selectable palettes, each of `2**IDX_W` 12-bit RGB entries. Writes go to a shadow bank; the shadow bank becomes active only at a frame boundary, so there is no mid-frame tearing. It sits between the sprite/background address generators and the VGA colour mux, with a 1-cycle registered lookup.

## Interface
- `IDX_W`, default 4: colour-index width; each palette has `2**IDX_W` entries.
- `NUM_PAL`, default 4: number of palettes; `PAL_W = $clog2(NUM_PAL)`, minimum 1.
- `COLOR_W`, default 4: width of each colour channel.

Ports (clock and reset first):
- `Clk`  in  1  sole clock; all state is updated on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `frame_start`  in  1  single-cycle pulse at the start of vertical blank.
- `rd_valid`  in  1  lookup request.
- `rd_pal`  in  `PAL_W`  palette select for the lookup.
- `rd_idx`  in  `IDX_W`  colour index for the lookup.
- `out_valid`  out  1  lookup result valid.
- `red`, `green`, `blue`  out  `COLOR_W` each  looked-up colour.
- `transparent`  out  1  the looked-up pixel is transparent.
- `wr_en`  in  1  shadow-bank write request.
- `wr_pal`  in  `PAL_W`  palette to write.
- `wr_idx`  in  `IDX_W`  entry to write.
- `wr_rgb`  in  `3*COLOR_W`  new colour, packed `{r,g,b}`.
- `wr_ready`  out  1  a write is accepted when `wr_en && wr_ready`.
- `commit_req`  in  1  pulse: make the shadow bank active at the next `frame_start`.
- `commit_busy`  out  1  a commit is pending or the sync copy is running.

## Operation
- Storage: two banks, A and B, each `NUM_PAL*2**IDX_W` entries. `act_sel` selects the active bank; the other bank is the shadow.
- Reset loads both banks with `DEFAULT_PAL` from the package. The reset value of `act_sel` is A.
- Lookups always read the active bank at address `{rd_pal, rd_idx}`.
- Writes always target the shadow bank at address `{wr_pal, wr_idx}`.
- FSM states: IDLE, PENDING, SYNC.
  - IDLE -> PENDING on `commit_req`. `commit_req` is ignored in PENDING and SYNC.
  - PENDING -> SYNC on `frame_start`. On that edge `act_sel` toggles.
  - SYNC: the copy counter walks addresses 0..ENTRIES-1, one entry per cycle, copying the new active bank into the new shadow bank. This keeps the shadow bank coherent with the active bank.
  - SYNC -> IDLE on the cycle the counter reaches ENTRIES-1. The counter is `$clog2(ENTRIES)` bits and clears on exit.
- `wr_ready` is high in IDLE, and high in PENDING except on the cycle `frame_start` is high. It is low throughout SYNC.
- Writes accepted in PENDING are included in the swap.
- `commit_busy` = (state != IDLE).
- A `frame_start` in IDLE has no effect. A `frame_start` during SYNC has no effect.
- A `Reset` asserted at any time, including mid-SYNC, restores defaults, sets state to IDLE and sets `act_sel` to A. No partial copy survives reset.

## Timing
- Reset values: `out_valid`=0, `red`/`green`/`blue`=0, `transparent`=0, `wr_ready`=1, `commit_busy`=0.
- Lookup latency is 1 cycle. A request sampled at edge N drives `out_valid` and the colour after edge N. `out_valid` is `rd_valid` delayed by 1 cycle.
- When `out_valid`=0 the colour outputs hold their previous value.
- A lookup sampled on the swap edge reads the old bank. Lookups from edge swap+1 onward read the new bank.
- A write accepted at edge N is visible in the active bank only after a subsequent swap.
- SYNC lasts exactly ENTRIES cycles. `commit_busy` falls on the edge that leaves SYNC.
- The earliest next commit is a `commit_req` sampled in IDLE.

## Configuration
- Macro: `PALETTE_TRANSPARENCY_EN`.
- Defined: a lookup with `rd_idx`==0 returns `transparent`=1 and RGB 0 regardless of the stored value.
- Not defined: `transparent` is tied to 0 and entry 0 is returned like any other entry.

## Structure
- Package `palette_pkg` holds:
  - the `rgb_t` packed struct of three `COLOR_W` fields;
  - `DEFAULT_PAL`, the 16-entry default colour table, replicated across palettes with the index truncated to `IDX_W`;
  - the FSM state enum.
- One sub-module, `palette_bank_ram`: a single bank with one write port and two read ports (lookup and copy), asynchronous reset-to-default. It is instantiated twice.

## Test plan
- Reset, then lookup pal 0 idx 1 -> after 1 cycle `out_valid`=1 and RGB = `DEFAULT_PAL[1]`; `wr_ready`=1, `commit_busy`=0.
- Write pal 1 idx 3 = 12'hF00, then look up pal 1 idx 3 before commit -> default value is returned, not F00.
- `commit_req`, then `frame_start` -> a lookup on the swap edge returns the old value; a lookup one cycle later returns F00; `commit_busy` stays high for exactly ENTRIES=64 further cycles.
- During SYNC, assert `wr_en` -> `wr_ready`=0 for all 64 cycles; after SYNC, the shadow bank holds F00 at pal 1 idx 3, so a second commit with no writes leaves the colour at F00.
- With `PALETTE_TRANSPARENCY_EN`, look up idx 0 -> `transparent`=1 and RGB 0. Without the macro -> `transparent`=0 and RGB = the stored entry.
- Assert `Reset` at copy count 20 of SYNC -> immediately state IDLE, `act_sel`=A, all entries at default, `commit_busy`=0.
